// File: rtl/mips_control_muldiv_sequencer_pkg.sv
// Shared encodings and decode helpers for the HI/LO multiply/divide sequencer.
package mips_control_muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mc_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2
  } mc_state_e;

  function automatic logic op_is_signed(mc_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_iterative(mc_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(mc_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_control_muldiv_sequencer_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on {hi_in, lo_in}.
module mips_control_muldiv_sequencer_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             fits;

  // Multiply: lo holds the remaining multiplier bits, product shifts right.
  assign sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);

  // Divide: lo holds dividend bits shifting out and quotient bits shifting in.
  // The partial remainder is always below the divisor, so sub fits in WIDTH bits.
  assign shifted = {hi_in, lo_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, operand});
  assign sub     = shifted[WIDTH-1:0] - operand;

  always_comb begin
    hi_out = sum[WIDTH:1];
    lo_out = {sum[0], lo_in[WIDTH-1:1]};
    if (is_div) begin
      hi_out = fits ? sub : shifted[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], fits};
    end
  end

endmodule

// File: rtl/mips_control_muldiv_sequencer.sv
// HI/LO owner: sequences iterative MULT/DIV, handles MTHI/MTLO, stall and flush restore.
module mips_control_muldiv_sequencer
  import mips_control_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             readRequest,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  mc_state_e        state;
  mc_op_e           op_e;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic [WIDTH-1:0] save_hi, save_lo;
  logic             is_div, neg_q, neg_r;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             sgn, a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign op_e      = mc_op_e'(op);
  assign busy      = (state != S_IDLE);
  assign stall     = busy & (readRequest | start);
  assign dbg_state = state;

  assign sgn   = op_is_signed(op_e);
  assign a_neg = sgn & dataA[WIDTH-1];
  assign b_neg = sgn & dataB[WIDTH-1];
  assign a_abs = a_neg ? -dataA : dataA;
  assign b_abs = b_neg ? -dataB : dataB;

  mips_control_muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .hi_in   (acc_hi),
    .lo_in   (acc_lo),
    .operand (operand),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // neg_q negates the whole product for multiply, the quotient for divide.
  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_r ? -acc_hi : acc_hi;
      fix_lo = neg_q ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      save_hi <= '0;
      save_lo <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && op_is_iterative(op_e)) begin
            is_div  <= op_is_div(op_e);
            operand <= op_is_div(op_e) ? b_abs : a_abs;
            acc_hi  <= '0;
            acc_lo  <= op_is_div(op_e) ? a_abs : b_abs;
            // Divide by zero keeps an all-ones quotient and hi equal to dataA.
            neg_q   <= (a_neg ^ b_neg) & (~op_is_div(op_e) | (|dataB));
            neg_r   <= a_neg;
            save_hi <= hi;
            save_lo <= lo;
            count   <= CW'(WIDTH - 1);
            state   <= S_RUN;
          end else if (start && op_e == OP_MTHI) begin
            hi <= dataA;
          end else if (start && op_e == OP_MTLO) begin
            lo <= dataA;
          end
        end
        S_RUN: begin
          if (flush) begin
            hi    <= save_hi;
            lo    <= save_lo;
            state <= S_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - 1'b1;
            if (count == '0) state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (flush) begin
            hi <= save_hi;
            lo <= save_lo;
          end else begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_muldiv_sequencer.sv
// Directed bench for the HI/LO multiply/divide sequencer with immediate-assertion checks.
module tb_mips_control_muldiv_sequencer;
  import mips_control_muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] dataA, dataB;
  logic         readRequest;
  logic         flush;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int total  = 0;
  int passed = 0;
  int n, nb, ns;

  always #5 clock = ~clock;

  mips_control_muldiv_sequencer #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .dataA       (dataA),
    .dataB       (dataB),
    .readRequest (readRequest),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .dbg_state   (dbg_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input mc_op_e o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    dataA = a;
    dataB = b;
    tick();
    start = 1'b0;
    op    = OP_NONE;
  endtask

  // Waits for done, counting elapsed, busy and stall cycles; bounded at 40 cycles.
  task automatic wait_done(output int cyc, output int bcyc, output int scyc);
    cyc = 0; bcyc = 0; scyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcyc++;
      if (stall === 1'b1) scyc++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_NONE; dataA = '0; dataB = '0;
    readRequest = 1'b0; flush = 1'b0;
    tick(); tick();
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    reset = 1'b0;
    tick();

    // 1: MULT -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_next", 64'(busy), 64'h1);
    wait_done(n, nb, ns);
    check("mult_latency", 64'(n), 64'd33);
    check("mult_busy_cycles", 64'(nb), 64'd33);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
    check("mult_busy_done", 64'(busy), 64'h0);
    tick();
    check("done_pulse", 64'(done), 64'h0);

    // 2: divides; an op presented while busy stalls and is not accepted
    issue(OP_DIVU, 32'd100, 32'd7);
    tick();
    start = 1'b1; op = OP_MULTU; dataA = 32'd9; dataB = 32'd9;
    #1;
    check("start_busy_stall", 64'(stall), 64'h1);
    tick();
    start = 1'b0; op = OP_NONE;
    wait_done(n, nb, ns);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    tick();
    check("held_op_not_taken", 64'(busy), 64'h0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, nb, ns);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    tick();
    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(n, nb, ns);
    check("div0_latency", 64'(n), 64'd33);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'd5);
    tick();

    // 3: MTHI then MULTU with readRequest held
    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'h0);
    check("mthi_done", 64'(done), 64'h0);
    readRequest = 1'b1;
    #1;
    check("idle_read_no_stall", 64'(stall), 64'h0);
    issue(OP_MULTU, 32'h1_0000, 32'h1_0000);
    wait_done(n, nb, ns);
    check("read_stall_cycles", 64'(ns), 64'd33);
    check("read_stall_after", 64'(stall), 64'h0);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'h0);
    readRequest = 1'b0;
    tick();

    // 4: flush mid-MULT restores hi/lo; a start alongside flush is ignored
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd0, 32'd0);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (10) tick();
    flush = 1'b1; start = 1'b1; op = OP_MULTU; dataA = 32'd7; dataB = 32'd7;
    tick();
    flush = 1'b0; start = 1'b0; op = OP_NONE;
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_hi", 64'(hi), 64'h0);
    check("flush_lo", 64'(lo), 64'h0);
    check("flush_done", 64'(done), 64'h0);
    repeat (25) tick();
    check("flush_no_late_done", 64'({busy, done}), 64'h0);
    issue(OP_MULTU, 32'd5, 32'd5);
    wait_done(n, nb, ns);
    check("post_flush_lo", 64'(lo), 64'd25);
    check("post_flush_hi", 64'(hi), 64'd0);
    tick();

    // 5: reset mid-DIVU
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) tick();
    reset = 1'b1; readRequest = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_stall", 64'(stall), 64'h0);
    readRequest = 1'b0;
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done(n, nb, ns);
    check("rst_next_lo", 64'(lo), 64'd333);
    check("rst_next_hi", 64'(hi), 64'd1);
    tick();

    // 6: signed overflow, then back-to-back MULTU in the done cycle
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, nb, ns);
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'h0);
    start = 1'b1; op = OP_MULTU; dataA = 32'd6; dataB = 32'd7;
    #1;
    check("b2b_no_stall", 64'(stall), 64'h0);
    tick();
    start = 1'b0; op = OP_NONE;
    check("b2b_accepted", 64'(busy), 64'h1);
    wait_done(n, nb, ns);
    check("b2b_latency", 64'(n), 64'd33);
    check("b2b_lo", 64'(lo), 64'd42);
    check("b2b_hi", 64'(hi), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
